cfs_md_rx_arbiter: RTL and testbench



---
 rtl/cfs_md_rx_arbiter_pkg.sv | 45 ++++
 rtl/cfs_rr_picker.sv | 25 ++
 rtl/cfs_md_rx_arbiter.sv | 146 ++++++++++++++
 tb/tb_cfs_md_rx_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfs_md_rx_arbiter_pkg.sv
// Shared types and helpers for the MD RX round-robin arbiter.
// next_rr() is sized for up to MAX_REQ requesters; callers zero-extend narrower vectors.
package cfs_md_rx_arbiter_pkg;

  localparam int MAX_REQ  = 16;
  localparam int RR_IDX_W = 4;
  localparam int BURST_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int offset_width(input int data_width);
    return (data_width <= 8) ? 1 : $clog2(data_width / 8);
  endfunction

  function automatic int size_width(input int data_width);
    return $clog2(data_width / 8) + 1;
  endfunction

  // First valid index strictly after last_idx, wrapping modulo num_req.
  // Returns last_idx when it is the only valid entry, or when nothing is valid.
  function automatic logic [RR_IDX_W-1:0] next_rr(input logic [MAX_REQ-1:0]  valid_vec,
                                                  input logic [RR_IDX_W-1:0] last_idx,
                                                  input int                  num_req);
    logic [RR_IDX_W-1:0] win;
    logic                found;
    int                  cand;
    win   = last_idx;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= num_req && !found) begin
        cand = int'(last_idx) + k;
        if (cand >= num_req) cand = cand - num_req;
        if (valid_vec[cand]) begin
          win   = RR_IDX_W'(cand);
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/cfs_rr_picker.sv
// Combinational round-robin priority picker: first valid index after last_idx, with wrap.
// Only meaningful when any_valid is 1; zero latency, no state.
module cfs_rr_picker
  import cfs_md_rx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_vec,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               any_valid,
  output logic [IDX_W-1:0]   pick_idx
);

  logic [MAX_REQ-1:0]  vec_ext;
  logic [RR_IDX_W-1:0] last_ext;
  logic [RR_IDX_W-1:0] win;

  assign vec_ext   = MAX_REQ'(valid_vec);
  assign last_ext  = RR_IDX_W'(last_idx);
  assign win       = next_rr(vec_ext, last_ext, NUM_REQ);
  assign pick_idx  = IDX_W'(win);
  assign any_valid = |valid_vec;

endmodule

// File: rtl/cfs_md_rx_arbiter.sv
// Round-robin arbiter sharing the aligner MD RX port among NUM_REQ requesters, 1-cycle arbitration,
// grant held through the handshake and up to MAX_BURST transfers. CFS_MD_RX_ARB_CNT_EN adds per-requester transfer counters.
module cfs_md_rx_arbiter
  import cfs_md_rx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ           = 4,
  parameter  int ALGN_DATA_WIDTH   = 32,
  parameter  int MAX_BURST         = 4,
  localparam int ALGN_OFFSET_WIDTH = offset_width(ALGN_DATA_WIDTH),
  localparam int ALGN_SIZE_WIDTH   = size_width(ALGN_DATA_WIDTH),
  localparam int GNT_WIDTH         = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   reset,
`ifdef CFS_MD_RX_ARB_CNT_EN
  input  logic                                   cnt_clr,
  output logic [NUM_REQ*16-1:0]                  xfer_cnt,
`endif
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ*ALGN_DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQ*ALGN_OFFSET_WIDTH-1:0]   req_offset,
  input  logic [NUM_REQ*ALGN_SIZE_WIDTH-1:0]     req_size,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     req_err,
  output logic                                   md_rx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]             md_rx_data,
  output logic [ALGN_OFFSET_WIDTH-1:0]           md_rx_offset,
  output logic [ALGN_SIZE_WIDTH-1:0]             md_rx_size,
  input  logic                                   md_rx_ready,
  input  logic                                   md_rx_err,
  output logic [GNT_WIDTH-1:0]                   gnt_idx,
  output logic                                   busy
);

  arb_state_t           state, state_nxt;
  logic [GNT_WIDTH-1:0] gnt_nxt;
  logic [BURST_W-1:0]   burst_cnt, burst_nxt, burst_inc;
  logic                 pick_vld;
  logic [GNT_WIDTH-1:0] pick_idx;
  logic                 in_grant;
  logic                 cur_valid;
  logic                 fire;
  logic                 burst_more;

  logic [ALGN_DATA_WIDTH-1:0]   data_arr   [NUM_REQ];
  logic [ALGN_OFFSET_WIDTH-1:0] offset_arr [NUM_REQ];
  logic [ALGN_SIZE_WIDTH-1:0]   size_arr   [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i]   = req_data[i*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
    assign offset_arr[i] = req_offset[i*ALGN_OFFSET_WIDTH +: ALGN_OFFSET_WIDTH];
    assign size_arr[i]   = req_size[i*ALGN_SIZE_WIDTH +: ALGN_SIZE_WIDTH];
  end

  cfs_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid_vec (req_valid),
    .last_idx  (gnt_idx),
    .any_valid (pick_vld),
    .pick_idx  (pick_idx)
  );

  // Reset gates the outputs in the cycle it is sampled, so the aligner sees valid withdrawn at once.
  assign in_grant   = (state == GRANT) && !reset;
  assign cur_valid  = req_valid[gnt_idx];
  assign fire       = in_grant && cur_valid && md_rx_ready;
  assign burst_inc  = (burst_cnt == {BURST_W{1'b1}}) ? burst_cnt : burst_cnt + 1'b1;
  assign burst_more = (int'(burst_cnt) + 1) < MAX_BURST;
  assign busy       = (state == GRANT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt_idx   <= GNT_WIDTH'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt_idx   <= gnt_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_idx;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nxt   = pick_idx;
          burst_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // A requester withdrawing valid ends its grant without counting a transfer.
        if (!cur_valid) begin
          state_nxt = IDLE;
        end else if (md_rx_ready) begin
          burst_nxt = burst_inc;
          if (!burst_more) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    md_rx_valid  = in_grant && cur_valid;
    md_rx_data   = '0;
    md_rx_offset = '0;
    md_rx_size   = '0;
    req_ready    = '0;
    req_err      = '0;
    if (in_grant) begin
      md_rx_data   = data_arr[gnt_idx];
      md_rx_offset = offset_arr[gnt_idx];
      md_rx_size   = size_arr[gnt_idx];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_grant && (gnt_idx == GNT_WIDTH'(i))) begin
        req_ready[i] = md_rx_ready;
        req_err[i]   = md_rx_err;
      end
    end
  end

`ifdef CFS_MD_RX_ARB_CNT_EN
  logic cnt_inc;
  assign cnt_inc = fire || (md_rx_valid && md_rx_err);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc && (gnt_idx == GNT_WIDTH'(i))) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign xfer_cnt[i*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_cfs_md_rx_arbiter.sv
// Directed bench for cfs_md_rx_arbiter: instance a uses MAX_BURST=1, instance b MAX_BURST=4, shared stimulus.
module tb_cfs_md_rx_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int GW = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR*OW-1:0]   req_offset;
  logic [NR*SW-1:0]   req_size;
  logic               md_rx_ready;
  logic               md_rx_err;
  logic               cnt_clr;

  logic [NR-1:0] req_ready_a, req_err_a, req_ready_b, req_err_b;
  logic          md_rx_valid_a, md_rx_valid_b, busy_a, busy_b;
  logic [DW-1:0] md_rx_data_a, md_rx_data_b;
  logic [OW-1:0] md_rx_offset_a, md_rx_offset_b;
  logic [SW-1:0] md_rx_size_a, md_rx_size_b;
  logic [GW-1:0] gnt_a, gnt_b;
`ifdef CFS_MD_RX_ARB_CNT_EN
  logic [NR*16-1:0] xfer_cnt_a, xfer_cnt_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cfs_md_rx_arbiter #(.NUM_REQ(NR), .ALGN_DATA_WIDTH(DW), .MAX_BURST(1)) u_dut_a (
    .clk          (clk),
    .reset        (reset),
`ifdef CFS_MD_RX_ARB_CNT_EN
    .cnt_clr      (cnt_clr),
    .xfer_cnt     (xfer_cnt_a),
`endif
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_offset   (req_offset),
    .req_size     (req_size),
    .req_ready    (req_ready_a),
    .req_err      (req_err_a),
    .md_rx_valid  (md_rx_valid_a),
    .md_rx_data   (md_rx_data_a),
    .md_rx_offset (md_rx_offset_a),
    .md_rx_size   (md_rx_size_a),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .gnt_idx      (gnt_a),
    .busy         (busy_a)
  );

  cfs_md_rx_arbiter #(.NUM_REQ(NR), .ALGN_DATA_WIDTH(DW), .MAX_BURST(4)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
`ifdef CFS_MD_RX_ARB_CNT_EN
    .cnt_clr      (cnt_clr),
    .xfer_cnt     (xfer_cnt_b),
`endif
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_offset   (req_offset),
    .req_size     (req_size),
    .req_ready    (req_ready_b),
    .req_err      (req_err_b),
    .md_rx_valid  (md_rx_valid_b),
    .md_rx_data   (md_rx_data_b),
    .md_rx_offset (md_rx_offset_b),
    .md_rx_size   (md_rx_size_b),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .gnt_idx      (gnt_b),
    .busy         (busy_b)
  );

  function automatic logic [DW-1:0] exp_data(input int i);
    return 32'hA500_0000 + 32'(i * 32'h0101);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW]   = exp_data(i);
      req_offset[i*OW +: OW] = OW'(i);
      req_size[i*SW +: SW]   = SW'(i + 1);
    end
    reset = 1'b1; req_valid = '0; md_rx_ready = 1'b0; md_rx_err = 1'b0; cnt_clr = 1'b0;
    tick(); tick();

    // Reset state, with inputs active while reset is held
    req_valid = 4'b1111; md_rx_ready = 1'b1; md_rx_err = 1'b1;
    tick();
    check("rst_gnt",   64'(gnt_a), 64'd3);
    check("rst_busy",  64'(busy_a), 64'd0);
    check("rst_valid", 64'(md_rx_valid_a), 64'd0);
    check("rst_ready", 64'(req_ready_a), 64'd0);
    check("rst_err",   64'(req_err_a), 64'd0);
    check("rst_data",  64'(md_rx_data_a), 64'd0);

    // MAX_BURST=1 strict round robin: 0,1,2,3,0 with an IDLE cycle between grants
    md_rx_err = 1'b0; reset = 1'b0;
    #1;
    check("idle_arb_valid", 64'(md_rx_valid_a), 64'd0);
    check("idle_arb_busy",  64'(busy_a), 64'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr_gnt",    64'(gnt_a), 64'(k % 4));
      check("rr_valid",  64'(md_rx_valid_a), 64'd1);
      check("rr_ready",  64'(req_ready_a), 64'(4'b0001 << (k % 4)));
      check("rr_data",   64'(md_rx_data_a), 64'(exp_data(k % 4)));
      check("rr_offset", 64'(md_rx_offset_a), 64'(k % 4));
      check("rr_size",   64'(md_rx_size_a), 64'((k % 4) + 1));
      tick();
      check("rr_bubble_busy",  64'(busy_a), 64'd0);
      check("rr_bubble_valid", 64'(md_rx_valid_a), 64'd0);
      tick();
    end

    // MAX_BURST=4 single requester 2: four back-to-back, one bubble, re-grant
    reset = 1'b1; req_valid = 4'b0100; md_rx_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      check("burst_busy",  64'(busy_b), 64'd1);
      check("burst_gnt",   64'(gnt_b), 64'd2);
      check("burst_ready", 64'(req_ready_b), 64'b0100);
      tick();
    end
    check("burst_bubble", 64'(busy_b), 64'd0);
    check("burst_bubble_valid", 64'(md_rx_valid_b), 64'd0);
    tick();
    check("burst_regnt_busy", 64'(busy_b), 64'd1);
    check("burst_regnt_gnt",  64'(gnt_b), 64'd2);

    // Requester 1 stalled by md_rx_ready low while everyone else waits
    reset = 1'b1; req_valid = 4'b0010; md_rx_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      check("stall_data",  64'(md_rx_data_b), 64'(exp_data(1)));
      check("stall_ready", 64'(req_ready_b), 64'd0);
      check("stall_gnt",   64'(gnt_b), 64'd1);
      check("stall_valid", 64'(md_rx_valid_b), 64'd1);
      tick();
    end
    md_rx_ready = 1'b1;
    #1;
    check("stall_release", 64'(req_ready_b), 64'b0010);
    tick();
    req_valid = 4'b1101; md_rx_ready = 1'b0;
    #1;
    check("drop1_valid", 64'(md_rx_valid_b), 64'd0);
    tick();
    check("drop1_idle", 64'(busy_b), 64'd0);
    tick();
    check("drop1_next", 64'(gnt_b), 64'd2);

    // Requester 0 withdraws valid mid-GRANT; next grant goes to 1
    reset = 1'b1; req_valid = 4'b0011; md_rx_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("drop0_gnt",   64'(gnt_b), 64'd0);
    check("drop0_valid", 64'(md_rx_valid_b), 64'd1);
    req_valid = 4'b0010;
    #1;
    check("drop0_same_cycle", 64'(md_rx_valid_b), 64'd0);
    tick();
    check("drop0_idle", 64'(busy_b), 64'd0);
    tick();
    check("drop0_next_gnt",  64'(gnt_b), 64'd1);
    check("drop0_next_busy", 64'(busy_b), 64'd1);

    // Reset sampled mid-transfer withdraws outputs in that same cycle
    md_rx_ready = 1'b1; reset = 1'b1;
    #1;
    check("rst_mid_valid", 64'(md_rx_valid_b), 64'd0);
    check("rst_mid_ready", 64'(req_ready_b), 64'd0);
    tick();
    check("rst_mid_busy", 64'(busy_b), 64'd0);
    check("rst_mid_gnt",  64'(gnt_b), 64'd3);

    // Error routed only to requester 3, only in the cycle it is asserted
    req_valid = 4'b1000; md_rx_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    md_rx_ready = 1'b1; md_rx_err = 1'b1;
    #1;
    check("err_bits",   64'(req_err_b), 64'b1000);
    check("err_ready",  64'(req_ready_b), 64'b1000);
    tick();
    md_rx_err = 1'b0;
    #1;
    check("err_cleared", 64'(req_err_b), 64'd0);
    md_rx_ready = 1'b0;

`ifdef CFS_MD_RX_ARB_CNT_EN
    // Three transfers on requester 1, then clear coincident with the fourth
    reset = 1'b1; req_valid = 4'b0010; md_rx_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("cnt_start", 64'(xfer_cnt_b[31:16]), 64'd0);
    tick(); tick(); tick();
    check("cnt_three", 64'(xfer_cnt_b[31:16]), 64'd3);
    check("cnt_other", 64'(xfer_cnt_b[15:0]), 64'd0);
    cnt_clr = 1'b1;
    #1;
    tick();
    check("cnt_cleared", 64'(xfer_cnt_b[31:16]), 64'd0);
    cnt_clr = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
